// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's data port: word RAM plus GPIO, a compare timer
// and an unmapped-access counter. Reads are combinational; writes commit at the clock edge.
module data_mem_responder #(
  parameter int unsigned RAM_WORDS = 768,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [9:0]        daddr,
  input  logic [31:0]       ddata_w,
  input  logic              d_w,
  input  logic              d_r,
  output logic [31:0]       ddata_r,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam logic [9:0] A_GPIO_OUT = 10'h300;
  localparam logic [9:0] A_GPIO_IN  = 10'h301;
  localparam logic [9:0] A_CNT      = 10'h302;
  localparam logic [9:0] A_CMP      = 10'h303;
  localparam logic [9:0] A_CTRL     = 10'h304;
  localparam logic [9:0] A_STAT     = 10'h305;
  localparam logic [9:0] A_ERR      = 10'h306;

  logic [31:0]       ram [RAM_WORDS];
  logic [GPIO_W-1:0] gpio_q;
  logic [GPIO_W-1:0] sync1;
  logic [GPIO_W-1:0] sync2;
  logic [31:0]       cnt;
  logic [31:0]       cmp;
  logic [2:0]        ctrl;
  logic              stat;
  logic [15:0]       err;

  logic        is_ram;
  logic        is_reg;
  logic        unmapped;
  logic        match;
  logic [31:0] rd_word;

  assign is_ram   = 32'(daddr) < RAM_WORDS;
  assign is_reg   = (daddr >= A_GPIO_OUT) && (daddr <= A_ERR);
  assign unmapped = (d_r | d_w) & ~is_ram & ~is_reg;
  assign match    = ctrl[0] && (cnt == cmp);

  // Read mux: addressed word before any same-cycle write
  always_comb begin
    rd_word = '0;
    if (is_ram) begin
      rd_word = ram[daddr];
    end else begin
      case (daddr)
        A_GPIO_OUT: rd_word = 32'(gpio_q);
        A_GPIO_IN:  rd_word = 32'(sync2);
        A_CNT:      rd_word = cnt;
        A_CMP:      rd_word = cmp;
        A_CTRL:     rd_word = {29'd0, ctrl};
        A_STAT:     rd_word = {31'd0, stat};
        A_ERR:      rd_word = {16'd0, err};
        default:    rd_word = '0;
      endcase
    end
  end

  assign ddata_r  = d_r ? rd_word : '0;
  assign gpio_out = gpio_q;
  assign irq      = stat & ctrl[2];

  // RAM is never reset; reset only suppresses a concurrent write
  always_ff @(posedge CLK) begin
    if (!RST && d_w && is_ram) begin
      ram[daddr] <= ddata_w;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      gpio_q <= '0;
      sync1  <= '0;
      sync2  <= '0;
      cnt    <= '0;
      cmp    <= '1;
      ctrl   <= '0;
      stat   <= 1'b0;
      err    <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (d_w && daddr == A_GPIO_OUT) gpio_q <= ddata_w[GPIO_W-1:0];
      if (d_w && daddr == A_CMP)      cmp    <= ddata_w;
      if (d_w && daddr == A_CTRL)     ctrl   <= ddata_w[2:0];

      // Load beats auto-clear, which beats counting
      if (d_w && daddr == A_CNT)  cnt <= ddata_w;
      else if (match && ctrl[1])  cnt <= '0;
      else if (ctrl[0])           cnt <= cnt + 32'd1;

      // A fresh match wins over a same-cycle W1C
      if (match)                                    stat <= 1'b1;
      else if (d_w && daddr == A_STAT && ddata_w[0]) stat <= 1'b0;

      if (d_w && daddr == A_ERR)            err <= '0;
      else if (unmapped && err != 16'hFFFF) err <= err + 16'd1;
    end
  end

endmodule
